// File: rtl/aud_recorder_param_if.sv
// SRAM write-side bundle of the audio recorder.
// The recorder drives it; the SRAM arbiter consumes it.
interface aud_recorder_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_ch;
    logic              o_valid;

    modport master (
        output o_address,
        output o_data,
        output o_ch,
        output o_valid
    );

    modport slave (
        input o_address,
        input o_data,
        input o_ch,
        input o_valid
    );
endinterface

// File: rtl/aud_recorder_param.sv
// I2S ADC deserialiser with start/pause/stop control that emits one
// SRAM write strobe per sample at an auto-incrementing address.
module aud_recorder_param #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 20,
    parameter int              NUM_CH   = 1,
    parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lrc,
    input  logic i_data,
    input  logic i_start,
    input  logic i_pause,
    input  logic i_stop,
    output logic o_busy,
    output logic o_full,
    aud_recorder_param_if.master wr
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam bit STEREO = (NUM_CH == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_WRITE,
        S_PAUSE,
        S_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-2:0] sh_q, sh_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ch_q, ch_d;
    logic              cap_ch_q, cap_ch_d;
    logic              lrc_q;
    logic              valid_q, busy_q, full_q;

    logic              left_e, right_e, cap_e;
    logic [DATA_W-1:0] sh_next;

    assign left_e  = lrc_q & ~i_lrc;
    assign right_e = ~lrc_q & i_lrc;
    assign cap_e   = left_e | (STEREO & right_e);
    assign sh_next = {sh_q, i_data};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sh_d     = sh_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        cap_ch_d = cap_ch_q;
        case (state_q)
            S_IDLE: begin
                if (!i_stop && !i_pause && i_start) begin
                    addr_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (cap_e) begin
                    cnt_d    = '0;
                    cap_ch_d = right_e;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (cap_e) begin
                    // resync: drop the partial sample, follow the new edge
                    cnt_d    = '0;
                    cap_ch_d = right_e;
                end else begin
                    sh_d  = sh_next[DATA_W-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        data_d  = sh_next;
                        ch_d    = cap_ch_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (addr_q == MAX_ADDR) begin
                    state_d = S_FULL;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = i_pause ? S_PAUSE : S_WAIT;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (!i_pause && i_start) begin
                    state_d = S_WAIT;
                end
            end
            S_FULL: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            sh_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ch_q     <= 1'b0;
            cap_ch_q <= 1'b0;
            lrc_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sh_q     <= sh_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            cap_ch_q <= cap_ch_d;
            lrc_q    <= i_lrc;
            valid_q  <= (state_d == S_WRITE);
            busy_q   <= (state_d == S_WAIT) ||
                        (state_d == S_SHIFT) ||
                        (state_d == S_WRITE);
            full_q   <= (state_d == S_FULL);
        end
    end

    assign wr.o_address = addr_q;
    assign wr.o_data    = data_q;
    assign wr.o_ch      = ch_q;
    assign wr.o_valid   = valid_q;
    assign o_busy       = busy_q;
    assign o_full       = full_q;
endmodule

// File: tb/tb_aud_recorder_param.sv
// Bench for aud_recorder_param: three configurations share one stimulus
// stream and are checked every cycle against a sample-level model.
module tb_aud_recorder_param;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lrc = 1'b0;
    logic din = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop = 1'b0;
    logic busy0, busy1, busy2, full0, full1, full2;

    int total = 0;
    int bad = 0;
    bit rnd = 1'b0;

    always #5 clk = ~clk;

    aud_recorder_param_if #(.DATA_W(DW), .ADDR_W(20)) b0 ();
    aud_recorder_param_if #(.DATA_W(DW), .ADDR_W(20)) b1 ();
    aud_recorder_param_if #(.DATA_W(DW), .ADDR_W(4))  b2 ();

    aud_recorder_param #(.DATA_W(DW), .ADDR_W(20), .NUM_CH(1)) u0 (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_busy(busy0), .o_full(full0), .wr(b0.master));
    aud_recorder_param #(.DATA_W(DW), .ADDR_W(20), .NUM_CH(2)) u1 (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_busy(busy1), .o_full(full1), .wr(b1.master));
    aud_recorder_param #(.DATA_W(DW), .ADDR_W(4), .NUM_CH(1),
                         .MAX_ADDR(4'd3)) u2 (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_busy(busy2), .o_full(full2), .wr(b2.master));

    logic [19:0] d_addr [3];
    logic [15:0] d_data [3];
    logic        d_ch [3], d_val [3], d_busy [3], d_full [3];

    assign d_addr[0] = b0.o_address;
    assign d_addr[1] = b1.o_address;
    assign d_addr[2] = {16'd0, b2.o_address};
    assign d_data[0] = b0.o_data;
    assign d_data[1] = b1.o_data;
    assign d_data[2] = b2.o_data;
    assign d_ch[0]   = b0.o_ch;
    assign d_ch[1]   = b1.o_ch;
    assign d_ch[2]   = b2.o_ch;
    assign d_val[0]  = b0.o_valid;
    assign d_val[1]  = b1.o_valid;
    assign d_val[2]  = b2.o_valid;
    assign d_busy[0] = busy0;
    assign d_busy[1] = busy1;
    assign d_busy[2] = busy2;
    assign d_full[0] = full0;
    assign d_full[1] = full1;
    assign d_full[2] = full2;

    // model: mode 0 idle, 1 recording, 2 paused, 3 full
    int          nch [3]  = '{1, 2, 1};
    int          maxa [3] = '{1048575, 1048575, 3};
    int          mode [3], bits [3], addr [3];
    logic [15:0] acc [3], mdata [3];
    bit          mch [3], cch [3], mwr [3];
    bit          lp;

    // strobe log: {ch, addr, data}
    logic [36:0] lg [3][$];

    task automatic model_step();
        bit le, re, cap, nw;
        if (rst) begin
            lp = 1'b0;
            for (int k = 0; k < 3; k++) begin
                mode[k] = 0; bits[k] = -1; addr[k] = 0;
                acc[k] = '0; mdata[k] = '0;
                mch[k] = 1'b0; cch[k] = 1'b0; mwr[k] = 1'b0;
            end
            return;
        end
        le = lp & ~lrc;
        re = ~lp & lrc;
        for (int k = 0; k < 3; k++) begin
            cap = le | ((nch[k] == 2) & re);
            nw = 1'b0;
            if (mwr[k]) begin
                if (stop) mode[k] = 0;
                else if (addr[k] == maxa[k]) mode[k] = 3;
                else begin
                    addr[k]++;
                    if (pause) mode[k] = 2;
                end
            end else begin
                case (mode[k])
                    0: if (!stop && !pause && start) begin
                        addr[k] = 0; mode[k] = 1;
                    end
                    1: if (stop) mode[k] = 0;
                    else if (pause) mode[k] = 2;
                    else if (cap) begin
                        bits[k] = 0; cch[k] = re;
                    end else if (bits[k] >= 0) begin
                        acc[k] = {acc[k][14:0], din};
                        bits[k]++;
                        if (bits[k] == DW) begin
                            mdata[k] = acc[k]; mch[k] = cch[k];
                            nw = 1'b1;
                        end
                    end
                    2: if (stop) mode[k] = 0;
                    else if (!pause && start) mode[k] = 1;
                    3: if (stop) mode[k] = 0;
                    default: mode[k] = 0;
                endcase
            end
            if (mode[k] != 1 || nw) bits[k] = -1;
            mwr[k] = nw;
        end
        lp = lrc;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [39:0] g, w;
            g = {d_val[k], d_busy[k], d_full[k], d_ch[k],
                 d_addr[k], d_data[k]};
            w = {mwr[k], mode[k] == 1, mode[k] == 3, mch[k],
                 addr[k][19:0], mdata[k]};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL cyc[%0d] t=%0t v/b/f/c/a/d got=%0h want=%0h",
                         k, $time, g, w);
            end
            if (d_val[k] === 1'b1)
                lg[k].push_back({d_ch[k], d_addr[k], d_data[k]});
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic half(input bit lv, input logic [15:0] v, input int len);
        @(negedge clk);
        lrc = lv;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            din = (i < DW) ? v[15-i] : 1'($urandom);
            if (rnd) begin
                start = ($urandom % 25) == 0;
                pause = ($urandom % 70) == 0;
                stop  = ($urandom % 120) == 0;
            end
        end
    endtask

    task automatic cmd(input bit s, input bit p, input bit t);
        @(negedge clk);
        start = s; pause = p; stop = t;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) lg[k].delete();
    endtask

    task automatic lr(input logic [15:0] v);
        half(1'b0, v, 20);
        half(1'b1, 16'h0, 20);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_addr", d_addr[0], 0);
        chk("rst_data", d_data[0], 0);
        chk("rst_flags", {d_val[0], d_busy[0], d_full[0], d_ch[0]}, 0);

        // mono frames
        cmd(1, 0, 0);
        half(1'b1, 16'h0, 20);
        lr(16'h8001);
        lr(16'h7FFE);
        chk("mono_n", lg[0].size(), 2);
        chk("mono0", lg[0][0], {1'b0, 20'd0, 16'h8001});
        chk("mono1", lg[0][1], {1'b0, 20'd1, 16'h7FFE});

        // stereo interleave
        do_reset();
        lrc = 1'b1;
        cmd(1, 0, 0);
        half(1'b0, 16'hA5A5, 20);
        half(1'b1, 16'h5A5A, 20);
        half(1'b0, 16'h0F0F, 20);
        chk("st_n", lg[1].size(), 3);
        chk("st0", lg[1][0], {1'b0, 20'd0, 16'hA5A5});
        chk("st1", lg[1][1], {1'b1, 20'd1, 16'h5A5A});
        chk("st2", lg[1][2], {1'b0, 20'd2, 16'h0F0F});

        // pause mid-shift then resume
        do_reset();
        half(1'b1, 16'h0, 3);
        cmd(1, 0, 0);
        lr(16'h1111); lr(16'h2222); lr(16'h3333);
        half(1'b0, 16'hFFFF, 6);
        cmd(0, 1, 0);
        half(1'b1, 16'h0, 20);
        lr(16'h4444); lr(16'h5555);
        chk("pause_n", lg[0].size(), 3);
        chk("pause_busy", d_busy[0], 0);
        cmd(1, 0, 0);
        lr(16'h1234);
        chk("resume", lg[0][3], {1'b0, 20'd3, 16'h1234});

        // stop mid-sample
        half(1'b0, 16'hBEEF, 8);
        cmd(0, 0, 1);
        chk("stop_addr", d_addr[0], 4);
        chk("stop_busy", d_busy[0], 0);
        chk("stop_n", lg[0].size(), 4);
        cmd(1, 0, 0);
        half(1'b1, 16'h0, 20);
        lr(16'hC0DE);
        chk("restart", lg[0][4], {1'b0, 20'd0, 16'hC0DE});

        // capacity limit
        do_reset();
        cmd(1, 0, 0);
        for (int i = 0; i < 6; i++) lr(16'(16'h1000 + i));
        chk("full_n", lg[2].size(), 4);
        chk("full_last", lg[2][3], {1'b0, 20'd3, 16'h1003});
        chk("full_flag", {d_full[2], d_addr[2]}, {1'b1, 20'd3});
        cmd(1, 0, 0);
        chk("full_start", {d_full[2], d_busy[2]}, 2'b10);
        cmd(0, 0, 1);
        chk("full_stop", {d_full[2], d_addr[2]}, {1'b0, 20'd3});

        // reset during shift
        do_reset();
        lrc = 1'b1;
        cmd(1, 0, 0);
        lr(16'h9999);
        half(1'b0, 16'h6666, 8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", {d_val[0], d_busy[0], d_ch[0], d_addr[0], d_data[0]},
            0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) lg[k].delete();

        // resync on early edge
        half(1'b1, 16'h0, 3);
        cmd(1, 0, 0);
        half(1'b0, 16'hAAAA, 10);
        half(1'b1, 16'h5555, 20);
        chk("resync_n", lg[1].size(), 1);
        chk("resync", lg[1][0], {1'b1, 20'd0, 16'h5555});

        // random traffic
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int len;
            len = (($urandom % 8) == 0) ? int'($urandom_range(4, 14))
                                        : int'($urandom_range(17, 24));
            half(($urandom % 6) == 0 ? lrc : ~lrc, 16'($urandom), len);
        end
        rnd = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
